// File: rtl/bitblaster_pkg.sv
// bitblaster_pkg: shared types and constants for the BitBlaster 10-bit datapath
package bitblaster_pkg;
    localparam int WORD_W = 10;
    localparam int NREGS  = 4;
    localparam logic [1:0] OP_REG  = 2'b00;
    localparam logic [1:0] OP_ADDI = 2'b10;
    localparam logic [1:0] OP_SUBI = 2'b11;
    typedef enum logic [3:0] {
        LOAD = 4'b0000,
        COPY = 4'b0001,
        ADD  = 4'b0010,
        SUB  = 4'b0011,
        INV  = 4'b0100,
        FLP  = 4'b0101,
        AND  = 4'b0110,
        OR   = 4'b0111,
        XOR  = 4'b1000,
        LSL  = 4'b1001,
        LSR  = 4'b1010,
        ASR  = 4'b1011,
        ADDI = 4'b1100,
        SUBI = 4'b1101
    } alu_fn_t;
    typedef enum logic [1:0] {T0, T1, T2, T3} seq_state_t;
endpackage

// File: rtl/decode2to4.sv
// decode2to4: 2-bit index plus enable to 4-bit one-hot
module decode2to4 (
    input  logic [1:0] idx_i,
    input  logic       en_i,
    output logic [3:0] onehot_o
);
    assign onehot_o = en_i ? 4'b0001 << idx_i : 4'b0000;
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle BitBlaster control unit; ALU_SEQ_ILLEGAL_FLAG_EN adds the Illegal output
module alu_sequencer
    import bitblaster_pkg::*;
(
    input  logic              CLKb,
    input  logic              Clr,
    input  logic              Exec,
    input  logic [WORD_W-1:0] INSTR,
    output logic              IRin,
    output logic              Ext,
    output logic              IMMout,
    output logic [WORD_W-1:0] IMM,
    output logic [NREGS-1:0]  Rout,
    output logic [NREGS-1:0]  Rin,
    output logic              Ain,
    output logic              Gin,
    output logic              Gout,
    output logic [3:0]        FN,
    output logic              Busy,
`ifdef ALU_SEQ_ILLEGAL_FLAG_EN
    output logic              Done,
    output logic              Illegal
`else
    output logic              Done
`endif
);
    seq_state_t        state_q, state_d;
    logic [WORD_W-1:0] ir_q, ir_d;
    logic [1:0]        op;
    logic [3:0]        f;
    logic              is_ld, is_cp, is_inv, is_flp, is_alu, is_imm, is_undef;
    logic              rout_en, rout_y, rin_en;

    assign op = ir_q[9:8];
    assign f  = ir_q[3:0];

    // instruction class decode from the frozen IR
    always_comb begin
        is_imm   = (op == OP_ADDI) || (op == OP_SUBI);
        is_ld    = (op == OP_REG) && (f == LOAD);
        is_cp    = (op == OP_REG) && (f == COPY);
        is_inv   = (op == OP_REG) && (f == INV);
        is_flp   = (op == OP_REG) && (f == FLP);
        is_alu   = (op == OP_REG) && (f inside {ADD, SUB, AND, OR, XOR, LSL, LSR, ASR});
        is_undef = !(is_imm || is_ld || is_cp || is_inv || is_flp || is_alu);
    end

    // timestep control decode and next state; the last step of every class raises Done and returns to T0
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        IRin    = 1'b0;
        Ext     = 1'b0;
        IMMout  = 1'b0;
        Ain     = 1'b0;
        Gin     = 1'b0;
        Gout    = 1'b0;
        FN      = LOAD;
        Done    = 1'b0;
        rout_en = 1'b0;
        rout_y  = 1'b0;
        rin_en  = 1'b0;
        case (state_q)
            T0: begin
                IRin = Exec && !Clr;
                if (Exec) begin
                    ir_d    = INSTR;
                    state_d = T1;
                end
            end
            T1: begin
                Ext     = is_ld;
                rin_en  = is_ld || is_cp;
                Done    = is_ld || is_cp || is_undef;
                rout_en = !(is_ld || is_undef);
                rout_y  = is_cp || is_inv || is_flp;
                Gin     = is_inv;
                FN      = is_inv ? INV : LOAD;
                Ain     = is_flp || is_alu || is_imm;
                state_d = Done ? T0 : T2;
            end
            T2: begin
                Gout    = is_inv;
                rin_en  = is_inv;
                Done    = is_inv;
                Gin     = is_flp || is_alu || is_imm;
                FN      = is_flp ? FLP : is_alu ? f : is_imm ? ((op == OP_SUBI) ? SUBI : ADDI) : LOAD;
                rout_en = is_alu;
                rout_y  = 1'b1;
                IMMout  = is_imm;
                state_d = Done ? T0 : T3;
            end
            default: begin
                Gout    = 1'b1;
                rin_en  = 1'b1;
                Done    = 1'b1;
                state_d = T0;
            end
        endcase
    end

    // falling-edge state and IR registers, shared edge with the ALU staging registers
    always_ff @(negedge CLKb) begin
        if (Clr) begin
            state_q <= T0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    assign Busy = state_q != T0;
    assign IMM  = IMMout ? {{(WORD_W-6){1'b0}}, ir_q[5:0]} : '0;

`ifdef ALU_SEQ_ILLEGAL_FLAG_EN
    assign Illegal = (state_q == T1) && is_undef;
`endif

    decode2to4 u_rin (
        .idx_i   (ir_q[7:6]),
        .en_i    (rin_en),
        .onehot_o(Rin)
    );

    decode2to4 u_rout (
        .idx_i   (rout_y ? ir_q[5:4] : ir_q[7:6]),
        .en_i    (rout_en),
        .onehot_o(Rout)
    );
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle control unit for the BitBlaster 10-bit datapath. Latches one 10-bit instruction, decodes it, and steps through up to three execute timesteps, driving the ALU staging controls (Ain, Gin, Gout, FN), the register-file one-hot read/write enables, and the shared-bus sources (external data, immediate). It sits between the instruction switches/Exec button and the register file, ALU and shared 10-bit bus. It guarantees at most one bus driver per cycle.

## Interface
- No parameters. Word width is fixed at 10 bits and there are 4 registers, from the shared package.
- CLKb  in  1  system clock; all state updates on the falling edge, the same edge as the ALU A/G registers.
- Clr  in  1  synchronous, active-high reset, sampled on the falling edge of CLKb.
- Exec  in  1  start request, sampled only in T0.
- INSTR  in  10  instruction word `op[9:8]_X[7:6]_Y[5:4]_FN[3:0]`, or `op[9:8]_X[7:6]_I[5:0]` when op[9]=1.
- IRin  out  1  high in T0 while Exec=1 (instruction latch strobe, for display).
- Ext  out  1  external data drives the bus.
- IMMout  out  1  immediate drives the bus.
- IMM  out  10  {4'b0, IR[5:0]}.
- Rout  out  4  one-hot register read enable.
- Rin  out  4  one-hot register write enable.
- Ain, Gin, Gout  out  1 each  ALU staging controls.
- FN  out  4  ALU function code.
- Busy  out  1  state != T0.
- Done  out  1  last timestep of the current instruction.

## Operation
- The state register holds T0, T1, T2 or T3. The internal IR is 10 bits. Clr → T0 and IR=0.
- T0: Exec=1 → IR<=INSTR, next state T1. Otherwise stay in T0. All outputs except IRin are 0.
- The IR is frozen from T1 to the end of the instruction. INSTR changes during execution are ignored.
- **ld** (op=00, FN=0000):
  - T1: Ext, Rin[X], Done.
- **cp** (FN=0001):
  - T1: Rout[Y], Rin[X], Done. This is a direct bus transfer; the ALU is not used.
- **inv** (FN=0100):
  - T1: Rout[Y], Gin, FN=0100.
  - T2: Gout, Rin[X], Done.
- **flp** (FN=0101):
  - T1: Rout[Y], Ain.
  - T2: Gin, FN=0101, with no bus driver.
  - T3: Gout, Rin[X], Done.
- **add/sub/and/or/xor/lsl/lsr/asr** (FN=0010, 0011, 0110–1011):
  - T1: Rout[X], Ain.
  - T2: Rout[Y], Gin, FN=IR[3:0].
  - T3: Gout, Rin[X], Done.
- **addi** (op=10) and **subi** (op=11):
  - T1: Rout[X], Ain.
  - T2: IMMout, Gin, FN=1100 for addi or 1101 for subi.
  - T3: Gout, Rin[X], Done.
- **Undefined** (op=01, or op=00 with FN 1100–1111):
  - T1: Done only.
  - No Rin, Gin or bus driver.
- After Done the next state is T0.
- FN is 0000 in every timestep without Gin.

## Timing
- Outputs are a combinational decode of state and IR. They are valid one half-cycle before the ALU/register falling edge that consumes them.
- Latency in CLKb cycles, Exec-sampling edge to return to T0:
  - ld, cp, undefined: 2.
  - inv: 3.
  - all others: 4.
- Exec held high issues instructions back-to-back. T0 lasts one cycle between instructions.
- Clr wins over Exec and over any state. Clr in T2 aborts the instruction: next edge → T0, all outputs 0, and no Rin is issued for the aborted instruction.
- Invariant: at most one of Ext, IMMout, Gout, |Rout is high. Rin and Rout are each $onehot0.

## Configuration
- `ALU_SEQ_ILLEGAL_FLAG_EN` defined:
  - Adds the output port Illegal (1 bit).
  - Illegal is high in T1 of an undefined instruction, together with Done.
  - Illegal is 0 after reset.
- Undefined: the port is absent, and undefined instructions complete silently as a 2-cycle no-op.

## Structure
- The shared package `bitblaster_pkg` holds:
  - the alu_fn_t enum: LOAD..SUBI, 0000–1101;
  - the seq_state_t enum: T0..T3;
  - op prefix constants: OP_REG=00, OP_ADDI=10, OP_SUBI=11;
  - WORD_W=10.
- Sub-module `decode2to4`: 2-bit index plus enable → 4-bit one-hot. It is instantiated for Rin and for Rout.

## Test plan
- Clr=1 for 2 edges with Exec=1 → state T0, all outputs 0, Busy=0.
- add R1,R2 (INSTR=10'b00_01_10_0010), Exec pulse → the following sequence, then T0:
  - T1: Rout=0010, Ain=1;
  - T2: Rout=0100, Gin=1, FN=0010;
  - T3: Gout=1, Rin=0010, Done=1.
- addi R3,5 (10'b10_11_000101) → T2: IMMout=1, IMM=10'b0000000101, FN=1100; T3: Rin=1000.
- ld R0 then cp R2,R0 with Exec held high:
  - ld T1: Ext=1, Rin=0001, Done=1;
  - T0 for one cycle;
  - cp T1: Rout=0001, Rin=0100, Done=1.
- Undefined 10'b01_00_000000 → Done in T1, Rin=0, Gin=0. Illegal=1 only with the macro defined.
- sub R0,R1 with Clr asserted in T2 → T0 on the next edge, Rin never asserted. The bus-exclusivity assertion holds throughout.
